// File: rtl/complex_magnitude_peak_pkg.sv
// Shared definitions for the complex-magnitude estimator: the approximation
// mode encoding and the default widths.
package complex_magnitude_pkg;

    localparam int unsigned DATA_WIDTH_DEFAULT  = 18;
    localparam int unsigned FRAME_LEN_DEFAULT   = 1024;
    localparam int unsigned INDEX_WIDTH_DEFAULT = 10;

    typedef enum logic [1:0] {
        MAG_AMBM_QUARTER = 2'd0,
        MAG_AMBM_3_8     = 2'd1,
        MAG_L1           = 2'd2,
        MAG_LINF         = 2'd3
    } mag_mode_e;

endpackage

// File: rtl/complex_magnitude_peak_if.sv
// Sample stream and result bundle of complex_magnitude_peak. The master side
// supplies I/Q samples; the slave side (the estimator) returns magnitudes and peaks.
interface complex_magnitude_peak_if
    import complex_magnitude_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEFAULT
);
    logic                          validIn;
    logic                          frameRestart;
    logic [1:0]                    mode;
    logic signed [DATA_WIDTH-1:0]  dataInRe;
    logic signed [DATA_WIDTH-1:0]  dataInIm;
    logic                          validOut;
    logic [DATA_WIDTH:0]           dataOut;
    logic                          peakValid;
    logic [DATA_WIDTH:0]           peakMag;
    logic [INDEX_WIDTH-1:0]        peakIndex;

    modport master (
        output validIn, frameRestart, mode, dataInRe, dataInIm,
        input  validOut, dataOut, peakValid, peakMag, peakIndex
    );

    modport slave (
        input  validIn, frameRestart, mode, dataInRe, dataInIm,
        output validOut, dataOut, peakValid, peakMag, peakIndex
    );

endinterface

// File: rtl/complex_magnitude_peak_tracker.sv
// Per-frame running-maximum search over the magnitude stream: sample index,
// best value and its index, frame restart and the end-of-frame pulse.
module peak_tracker
    import complex_magnitude_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int unsigned FRAME_LEN   = FRAME_LEN_DEFAULT,
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEFAULT
) (
    input  logic                   clock,
    input  logic                   resetN,
    input  logic                   enable,
    input  logic                   sample_valid,
    input  logic                   sample_restart,
    input  logic [DATA_WIDTH:0]    sample_mag,
    output logic                   peak_valid,
    output logic [DATA_WIDTH:0]    peak_mag,
    output logic [INDEX_WIDTH-1:0] peak_index
);
    localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(FRAME_LEN - 1);
    localparam logic [INDEX_WIDTH-1:0] IDX_ONE  = INDEX_WIDTH'(1);

    logic [INDEX_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH:0]    max_q, max_d;
    logic [INDEX_WIDTH-1:0] max_idx_q, max_idx_d;
    logic                   pv_q, pv_d;
    logic [DATA_WIDTH:0]    pm_q, pm_d;
    logic [INDEX_WIDTH-1:0] pi_q, pi_d;

    logic [INDEX_WIDTH-1:0] cur_idx;
    logic                   take;

    always_comb begin
        idx_d     = idx_q;
        max_d     = max_q;
        max_idx_d = max_idx_q;
        pv_d      = pv_q;
        pm_d      = pm_q;
        pi_d      = pi_q;
        cur_idx   = sample_restart ? '0 : idx_q;
        // index 0 always reloads, so ties keep the first occurrence via strict '>'
        take      = (cur_idx == '0) || (sample_mag > max_q);
        if (enable) begin
            pv_d = 1'b0;
            if (sample_valid) begin
                max_d     = take ? sample_mag : max_q;
                max_idx_d = take ? cur_idx : max_idx_q;
                if (cur_idx == LAST_IDX) begin
                    pv_d  = 1'b1;
                    pm_d  = max_d;
                    pi_d  = max_idx_d;
                    idx_d = '0;
                end else begin
                    idx_d = cur_idx + IDX_ONE;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            idx_q     <= '0;
            max_q     <= '0;
            max_idx_q <= '0;
            pv_q      <= 1'b0;
            pm_q      <= '0;
            pi_q      <= '0;
        end else begin
            idx_q     <= idx_d;
            max_q     <= max_d;
            max_idx_q <= max_idx_d;
            pv_q      <= pv_d;
            pm_q      <= pm_d;
            pi_q      <= pi_d;
        end
    end

    assign peak_valid = pv_q;
    assign peak_mag   = pm_q;
    assign peak_index = pi_q;

endmodule

// File: rtl/complex_magnitude_peak.sv
// Three-stage complex-magnitude estimator (abs, sort, combine) with an optional
// per-frame peak search built only when PEAK_SEARCH_EN is defined.
module complex_magnitude_peak
    import complex_magnitude_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DATA_WIDTH_DEFAULT,
    parameter int unsigned FRAME_LEN   = FRAME_LEN_DEFAULT,
    parameter int unsigned INDEX_WIDTH = INDEX_WIDTH_DEFAULT
) (
    input  logic                      clock,
    input  logic                      resetN,
    input  logic                      enable,
    complex_magnitude_peak_if.slave   bus
);
    generate
        if (FRAME_LEN < 2 || (64'(1) << INDEX_WIDTH) < 64'(FRAME_LEN)) begin : g_bad_cfg
            $error("complex_magnitude_peak: FRAME_LEN/INDEX_WIDTH out of range");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] re_u, im_u;

    logic                  v1_q, v1_d;
    logic [DATA_WIDTH-1:0] a1_q, a1_d, b1_q, b1_d;
    mag_mode_e             mode1_q, mode1_d;
    logic                  v2_q, v2_d;
    logic [DATA_WIDTH-1:0] mx2_q, mx2_d, mn2_q, mn2_d;
    mag_mode_e             mode2_q, mode2_d;
    logic                  v3_q, v3_d;
    logic [DATA_WIDTH:0]   mag3_q, mag3_d;
    logic [DATA_WIDTH:0]   mx_e, mn_e;

    always_comb begin
        v1_d    = v1_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        mode1_d = mode1_q;
        v2_d    = v2_q;
        mx2_d   = mx2_q;
        mn2_d   = mn2_q;
        mode2_d = mode2_q;
        v3_d    = v3_q;
        mag3_d  = mag3_q;
        re_u    = bus.dataInRe;
        im_u    = bus.dataInIm;
        mx_e    = {1'b0, mx2_q};
        mn_e    = {1'b0, mn2_q};
        if (enable) begin
            // unsigned negate keeps -2^(W-1) as 2^(W-1) instead of wrapping
            v1_d    = bus.validIn;
            a1_d    = re_u[DATA_WIDTH-1] ? ('0 - re_u) : re_u;
            b1_d    = im_u[DATA_WIDTH-1] ? ('0 - im_u) : im_u;
            mode1_d = mag_mode_e'(bus.mode);

            v2_d    = v1_q;
            mx2_d   = (a1_q >= b1_q) ? a1_q : b1_q;
            mn2_d   = (a1_q >= b1_q) ? b1_q : a1_q;
            mode2_d = mode1_q;

            v3_d    = v2_q;
            case (mode2_q)
                MAG_AMBM_QUARTER: mag3_d = mx_e + (mn_e >> 2);
                MAG_AMBM_3_8:     mag3_d = mx_e + (mn_e >> 2) + (mn_e >> 3);
                MAG_L1:           mag3_d = mx_e + mn_e;
                MAG_LINF:         mag3_d = mx_e;
                default:          mag3_d = mx_e;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            v1_q    <= 1'b0;
            a1_q    <= '0;
            b1_q    <= '0;
            mode1_q <= MAG_AMBM_QUARTER;
            v2_q    <= 1'b0;
            mx2_q   <= '0;
            mn2_q   <= '0;
            mode2_q <= MAG_AMBM_QUARTER;
            v3_q    <= 1'b0;
            mag3_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            mode1_q <= mode1_d;
            v2_q    <= v2_d;
            mx2_q   <= mx2_d;
            mn2_q   <= mn2_d;
            mode2_q <= mode2_d;
            v3_q    <= v3_d;
            mag3_q  <= mag3_d;
        end
    end

    assign bus.validOut = v3_q;
    assign bus.dataOut  = mag3_q;

`ifdef PEAK_SEARCH_EN
    logic rs1_q, rs1_d, rs2_q, rs2_d, rs3_q, rs3_d;

    always_comb begin
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        rs3_d = rs3_q;
        if (enable) begin
            rs1_d = bus.validIn & bus.frameRestart;
            rs2_d = rs1_q;
            rs3_d = rs2_q;
        end
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            rs1_q <= 1'b0;
            rs2_q <= 1'b0;
            rs3_q <= 1'b0;
        end else begin
            rs1_q <= rs1_d;
            rs2_q <= rs2_d;
            rs3_q <= rs3_d;
        end
    end

    peak_tracker #(
        .DATA_WIDTH (DATA_WIDTH),
        .FRAME_LEN  (FRAME_LEN),
        .INDEX_WIDTH(INDEX_WIDTH)
    ) u_peak_tracker (
        .clock         (clock),
        .resetN        (resetN),
        .enable        (enable),
        .sample_valid  (v3_q),
        .sample_restart(rs3_q),
        .sample_mag    (mag3_q),
        .peak_valid    (bus.peakValid),
        .peak_mag      (bus.peakMag),
        .peak_index    (bus.peakIndex)
    );
`else
    assign bus.peakValid = 1'b0;
    assign bus.peakMag   = '0;
    assign bus.peakIndex = '0;
`endif

endmodule

// File: tb/tb_complex_magnitude_peak.sv
// Bench for complex_magnitude_peak: a delay-line/frame-list model checked every
// cycle, plus directed vectors with hand-computed literal results.
module tb_complex_magnitude_peak;
    localparam int DW = 18;
    localparam int FL = 4;
    localparam int IW = 10;

    logic clock = 1'b0;
    logic resetN = 1'b1;
    logic enable = 1'b1;

    complex_magnitude_peak_if #(.DATA_WIDTH(DW), .INDEX_WIDTH(IW)) bus ();

    complex_magnitude_peak #(.DATA_WIDTH(DW), .FRAME_LEN(FL), .INDEX_WIDTH(IW)) dut (
        .clock (clock),
        .resetN(resetN),
        .enable(enable),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int mag_model(input int re, input int im, input int mode);
        int a, b, mx, mn;
        a  = (re < 0) ? -re : re;
        b  = (im < 0) ? -im : im;
        mx = (a > b) ? a : b;
        mn = (a > b) ? b : a;
        case (mode)
            0: return mx + mn / 4;
            1: return mx + mn / 4 + mn / 8;
            2: return a + b;
            default: return mx;
        endcase
    endfunction

    // ---------------- model: delay line in enabled cycles + frame list --------
    typedef struct { bit v; int mag; bit rs; } stage_t;
    stage_t pipe [3];
    int frame [$];
    int exp_pv = 0, exp_pm = 0, exp_pi = 0;

    always @(posedge clock) begin
        if (!resetN) begin
            for (int i = 0; i < 3; i++) pipe[i] = '{v: 1'b0, mag: 0, rs: 1'b0};
            frame.delete();
            exp_pv = 0; exp_pm = 0; exp_pi = 0;
        end else if (enable) begin
`ifdef PEAK_SEARCH_EN
            exp_pv = 0;
            if (pipe[2].v) begin
                if (pipe[2].rs) frame.delete();
                frame.push_back(pipe[2].mag);
                if (frame.size() == FL) begin
                    int best, bi;
                    best = -1; bi = 0;
                    foreach (frame[k]) if (frame[k] > best) begin best = frame[k]; bi = k; end
                    exp_pv = 1; exp_pm = best; exp_pi = bi;
                    frame.delete();
                end
            end
`endif
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0].v   = bus.validIn;
            pipe[0].mag = mag_model(int'(bus.dataInRe), int'(bus.dataInIm), int'(bus.mode));
            pipe[0].rs  = bus.validIn & bus.frameRestart;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clock) begin
        if (!resetN) begin
            chk("rst_validOut", int'(bus.validOut), 0);
            chk("rst_dataOut", int'(bus.dataOut), 0);
            chk("rst_peakValid", int'(bus.peakValid), 0);
            chk("rst_peakMag", int'(bus.peakMag), 0);
            chk("rst_peakIndex", int'(bus.peakIndex), 0);
        end else begin
            chk("validOut", int'(bus.validOut), int'(pipe[2].v));
            if (pipe[2].v) chk("dataOut", int'(bus.dataOut), pipe[2].mag);
            chk("peakValid", int'(bus.peakValid), exp_pv);
            chk("peakMag", int'(bus.peakMag), exp_pm);
            chk("peakIndex", int'(bus.peakIndex), exp_pi);
        end
    end

    // ---------------- directed vectors ----------------
    typedef struct { int re; int im; int mode; int rs; int lit; } vec_t;
    vec_t vq [$];

    task automatic push(input int re, input int im, input int mode, input int rs, input int lit);
        vq.push_back('{re: re, im: im, mode: mode, rs: rs, lit: lit});
    endtask

    task automatic drive(input int re, input int im, input int mode, input int rs, input bit v);
        bus.validIn      = v;
        bus.dataInRe     = DW'(re);
        bus.dataInIm     = DW'(im);
        bus.mode         = 2'(mode);
        bus.frameRestart = rs[0];
    endtask

    // entered and left 2 time units after a rising edge
    task automatic run_vec(input string tag);
        int n;
        n = vq.size();
        enable = 1'b1;
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) drive(vq[i].re, vq[i].im, vq[i].mode, vq[i].rs, 1'b1);
            else       drive(0, 0, 0, 0, 1'b0);
            @(posedge clock); #1;
            if (i >= 2) begin
                chk($sformatf("%s[%0d].valid", tag, i - 2), int'(bus.validOut), 1);
                chk($sformatf("%s[%0d].data", tag, i - 2), int'(bus.dataOut), vq[i - 2].lit);
            end
            #1;
        end
        vq.delete();
    endtask

    task automatic chk_peak(input string tag, input int m, input int idx);
        @(posedge clock); #1;
        chk({tag, ".peakValid"}, int'(bus.peakValid), 1);
        chk({tag, ".peakMag"}, int'(bus.peakMag), m);
        chk({tag, ".peakIndex"}, int'(bus.peakIndex), idx);
        #1;
    endtask

    task automatic frame4(input int m0, input int m1, input int m2, input int m3, input int rs0);
        push(m0, 0, 3, rs0, m0);
        push(m1, 0, 3, 0, m1);
        push(m2, 0, 3, 0, m2);
        push(m3, 0, 3, 0, m3);
    endtask

    initial begin
        drive(0, 0, 0, 0, 1'b0);
        #1 resetN = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_dataOut_lit", int'(bus.dataOut), 0);
        chk("reset_peakMag_lit", int'(bus.peakMag), 0);
        #1 resetN = 1'b1;

        // mode 0 isolated samples
        push(59, 15683, 0, 0, 15697);          run_vec("m0_a");
        push(-131000, 69420, 0, 0, 148355);    run_vec("m0_b");
        push(0, -1357, 0, 0, 1357);            run_vec("m0_c");

        // modes rotating every sample, back-to-back
        push(59, 15683, 1, 0, 15704);
        push(59, 15683, 2, 0, 15742);
        push(59, 15683, 3, 0, 15683);
        push(59, 15683, 0, 0, 15697);
        push(-131000, 69420, 3, 0, 131000);
        run_vec("mode_rot");

        // most negative input on both axes
        push(-131072, -131072, 2, 0, 262144);
        push(-131072, -131072, 0, 0, 163840);
        push(-131072, -131072, 1, 0, 180224);
        push(-131072, -131072, 3, 0, 131072);
        push(131071, -131072, 2, 0, 262143);
        run_vec("edge");

`ifdef PEAK_SEARCH_EN
        frame4(5, 9, 9, 2, 1);  run_vec("pk1"); chk_peak("pk1", 9, 1);
        frame4(1, 1, 1, 7, 0);  run_vec("pk2"); chk_peak("pk2", 7, 3);
        push(3, 0, 3, 0, 3); push(4, 0, 3, 0, 4);
        frame4(6, 8, 1, 2, 1);  run_vec("rst3"); chk_peak("rst3", 8, 1);
        push(1, 0, 3, 0, 1); push(2, 0, 3, 0, 2); push(3, 0, 3, 0, 3);
        frame4(9, 0, 0, 0, 1);  run_vec("rstlast"); chk_peak("rstlast", 9, 0);
`endif

        // random stream with enable and validIn toggling
        for (int i = 0; i < 400; i++) begin
            enable = ($urandom_range(3) != 0);
            drive(int'($signed(DW'($urandom))), int'($signed(DW'($urandom))),
                  int'($urandom_range(3)), int'($urandom_range(7) == 0), $urandom_range(2) != 0);
            @(posedge clock); #2;
        end
        enable = 1'b1;
        drive(0, 0, 0, 0, 1'b0);
        repeat (6) @(posedge clock);
        #2;

        // reset mid-frame with samples in flight
        drive(11, 0, 3, 1, 1'b1); @(posedge clock); #2;
        drive(12, 0, 3, 0, 1'b1); @(posedge clock); #2;
        drive(13, 0, 3, 0, 1'b1); @(posedge clock); #2;
        drive(0, 0, 0, 0, 1'b0);
        chk("inflight_valid", int'(bus.validOut), 1);
        resetN = 1'b0;
        #1;
        chk("midrst_validOut", int'(bus.validOut), 0);
        chk("midrst_dataOut", int'(bus.dataOut), 0);
        chk("midrst_peakValid", int'(bus.peakValid), 0);
        chk("midrst_peakMag", int'(bus.peakMag), 0);
        chk("midrst_peakIndex", int'(bus.peakIndex), 0);
        @(posedge clock); #2;
        resetN = 1'b1;

`ifdef PEAK_SEARCH_EN
        frame4(5, 9, 9, 2, 0);  run_vec("post_rst"); chk_peak("post_rst", 9, 1);
`else
        frame4(5, 9, 9, 2, 0);  run_vec("post_rst");
`endif
        repeat (4) @(posedge clock);
        #2;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
